// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl_if
// Brief    : Pipeline-side hazard inputs and stall-control outputs grouped
//            for the load-use / memory-busy stall controller.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] rd_ex;
  logic             is_load_ex;
  logic [REG_W-1:0] ra_id;
  logic [REG_W-1:0] rb_id;
  logic             ra_used_id;
  logic             rb_used_id;
  logic             mem_busy;
  logic             flush_ex;
  logic             stall_pc;
  logic             stall_id;
  logic             bubble_ex;
  logic             freeze_all;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side drives hazard information and consumes stall controls.
  modport master (
    output rd_ex, is_load_ex, ra_id, rb_id, ra_used_id, rb_used_id,
           mem_busy, flush_ex,
    input  stall_pc, stall_id, bubble_ex, freeze_all, stall_cnt
  );

  modport slave (
    input  rd_ex, is_load_ex, ra_id, rb_id, ra_used_id, rb_used_id,
           mem_busy, flush_ex,
    output stall_pc, stall_id, bubble_ex, freeze_all, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Load-use hazard detector inserting LOAD_LAT bubbles, with
//            memory-busy freeze, branch-flush priority and a saturating
//            load-use stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_W       = 5,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int CNT_W       = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LSTALL = 1'b1
  } state_t;

  localparam logic [3:0] C_REM_INIT = 4'(LOAD_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_rem;
  logic [3:0]       w_rem_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_cnt_inc;
  logic             w_exempt;
  logic             w_hz;
  logic             w_stall_pc;
  logic             w_stall_id;
  logic             w_bubble_ex;
  logic             w_freeze_all;

  generate
    if (ZERO_EXEMPT != 0) begin : g_zero_exempt
      assign w_exempt = (bus.rd_ex == '0);
    end else begin : g_no_zero_exempt
      assign w_exempt = 1'b0;
    end
  endgenerate

  assign w_hz = bus.is_load_ex
              & ((bus.ra_used_id & (bus.ra_id == bus.rd_ex))
               | (bus.rb_used_id & (bus.rb_id == bus.rd_ex)))
              & ~w_exempt;

  // Priority: memory freeze, then flush, then load-use stall.
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_cnt_inc    = 1'b0;
    w_stall_pc   = 1'b0;
    w_stall_id   = 1'b0;
    w_bubble_ex  = 1'b0;
    w_freeze_all = 1'b0;

    if (!rst_n) begin
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = 4'd0;
    end else if (bus.mem_busy) begin
      w_freeze_all = 1'b1;
      w_stall_pc   = 1'b1;
      w_stall_id   = 1'b1;
    end else if (bus.flush_ex) begin
      w_bubble_ex = 1'b1;
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = 4'd0;
    end else if (r_state == ST_IDLE) begin
      if (w_hz) begin
        w_stall_pc  = 1'b1;
        w_stall_id  = 1'b1;
        w_bubble_ex = 1'b1;
        w_cnt_inc   = 1'b1;
        if (LOAD_LAT > 1) begin
          w_state_nxt = ST_LSTALL;
          w_rem_nxt   = C_REM_INIT;
        end
      end
    end else begin
      // EX holds a bubble here, so the hazard term is not consulted.
      w_stall_pc  = 1'b1;
      w_stall_id  = 1'b1;
      w_bubble_ex = 1'b1;
      w_cnt_inc   = 1'b1;
      w_rem_nxt   = r_rem - 4'd1;
      if (r_rem == 4'd1) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_cnt_inc && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_pc   = w_stall_pc;
  assign bus.stall_id   = w_stall_id;
  assign bus.bubble_ex  = w_bubble_ex;
  assign bus.freeze_all = w_freeze_all;
  assign bus.stall_cnt  = rst_n ? r_stall_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed self-checking bench over four parameterisations of
//            hazard_stall_ctrl sharing one stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rd_ex, ra_id, rb_id;
  logic       is_load_ex, ra_used_id, rb_used_id, mem_busy, flush_ex;
  int         n_checks;
  int         n_errors;

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) if_l1 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) if_l3 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) if_z0 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  if_c4 ();

  assign if_l1.rd_ex = rd_ex; assign if_l1.is_load_ex = is_load_ex;
  assign if_l1.ra_id = ra_id; assign if_l1.rb_id = rb_id;
  assign if_l1.ra_used_id = ra_used_id; assign if_l1.rb_used_id = rb_used_id;
  assign if_l1.mem_busy = mem_busy; assign if_l1.flush_ex = flush_ex;
  assign if_l3.rd_ex = rd_ex; assign if_l3.is_load_ex = is_load_ex;
  assign if_l3.ra_id = ra_id; assign if_l3.rb_id = rb_id;
  assign if_l3.ra_used_id = ra_used_id; assign if_l3.rb_used_id = rb_used_id;
  assign if_l3.mem_busy = mem_busy; assign if_l3.flush_ex = flush_ex;
  assign if_z0.rd_ex = rd_ex; assign if_z0.is_load_ex = is_load_ex;
  assign if_z0.ra_id = ra_id; assign if_z0.rb_id = rb_id;
  assign if_z0.ra_used_id = ra_used_id; assign if_z0.rb_used_id = rb_used_id;
  assign if_z0.mem_busy = mem_busy; assign if_z0.flush_ex = flush_ex;
  assign if_c4.rd_ex = rd_ex; assign if_c4.is_load_ex = is_load_ex;
  assign if_c4.ra_id = ra_id; assign if_c4.rb_id = rb_id;
  assign if_c4.ra_used_id = ra_used_id; assign if_c4.rb_used_id = rb_used_id;
  assign if_c4.mem_busy = mem_busy; assign if_c4.flush_ex = flush_ex;

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .ZERO_EXEMPT(1), .CNT_W(32))
    u_l1 (.clk(clk), .rst_n(rst_n), .bus(if_l1));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .ZERO_EXEMPT(1), .CNT_W(32))
    u_l3 (.clk(clk), .rst_n(rst_n), .bus(if_l3));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .ZERO_EXEMPT(0), .CNT_W(32))
    u_z0 (.clk(clk), .rst_n(rst_n), .bus(if_z0));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .ZERO_EXEMPT(1), .CNT_W(4))
    u_c4 (.clk(clk), .rst_n(rst_n), .bus(if_c4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after each rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    rd_ex = '0; ra_id = '0; rb_id = '0;
    is_load_ex = 1'b0; ra_used_id = 1'b0; rb_used_id = 1'b0;
    mem_busy = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_ex = 5'd5; ra_id = 5'd5; is_load_ex = 1'b1; ra_used_id = 1'b1;
    mem_busy = 1'b0; flush_ex = 1'b0; rb_id = '0; rb_used_id = 1'b0;
    tick();
    #1;
    n_checks++;
    if (if_l1.bubble_ex !== 1'b0 || if_l1.stall_pc !== 1'b0 ||
        if_l1.stall_id !== 1'b0 || if_l1.freeze_all !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got pc=%b id=%b bub=%b frz=%b want all 0",
               if_l1.stall_pc, if_l1.stall_id, if_l1.bubble_ex, if_l1.freeze_all);
    end
    n_checks++;
    if (if_l3.stall_cnt !== 32'd0 || if_c4.stall_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_cnt: got l3=%0d c4=%0d want 0", if_l3.stall_cnt, if_c4.stall_cnt);
    end
    do_reset();
  endtask

  task automatic test_single_bubble();
    do_reset();
    tick();
    rd_ex = 5'd5; is_load_ex = 1'b1; ra_id = 5'd5; ra_used_id = 1'b1;
    #1;
    n_checks++;
    if (if_l1.stall_pc !== 1'b1 || if_l1.stall_id !== 1'b1 || if_l1.bubble_ex !== 1'b1) begin
      n_errors++;
      $display("FAIL lat1_stall: got pc=%b id=%b bub=%b want 1 1 1",
               if_l1.stall_pc, if_l1.stall_id, if_l1.bubble_ex);
    end
    n_checks++;
    if (if_l1.stall_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL lat1_cnt_before: got %0d want 0", if_l1.stall_cnt);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (if_l1.bubble_ex !== 1'b0 || if_l1.stall_pc !== 1'b0) begin
      n_errors++;
      $display("FAIL lat1_release: got bub=%b pc=%b want 0 0", if_l1.bubble_ex, if_l1.stall_pc);
    end
    n_checks++;
    if (if_l1.stall_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL lat1_cnt_after: got %0d want 1", if_l1.stall_cnt);
    end
  endtask

  task automatic test_multi_bubble();
    logic [3:0] exp_bub;
    exp_bub = 4'b0111;  // bit i = expected bubble in cycle i
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_inputs();
      if (i == 0) begin
        rd_ex = 5'd7; is_load_ex = 1'b1; rb_id = 5'd7; rb_used_id = 1'b1;
      end
      #1;
      n_checks++;
      if (if_l3.bubble_ex !== exp_bub[i] || if_l3.stall_pc !== exp_bub[i]) begin
        n_errors++;
        $display("FAIL lat3_bubble[%0d]: got bub=%b pc=%b want %b",
                 i, if_l3.bubble_ex, if_l3.stall_pc, exp_bub[i]);
      end
    end
    n_checks++;
    if (if_l3.stall_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL lat3_cnt: got %0d want 3", if_l3.stall_cnt);
    end
    tick();
    rd_ex = 5'd7; is_load_ex = 1'b1; ra_id = 5'd7; rb_id = 5'd7;
    ra_used_id = 1'b0; rb_used_id = 1'b0;
    #1;
    n_checks++;
    if (if_l3.bubble_ex !== 1'b0) begin
      n_errors++;
      $display("FAIL lat3_unused_src: got bub=%b want 0", if_l3.bubble_ex);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (if_l3.stall_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL lat3_unused_cnt: got %0d want 3", if_l3.stall_cnt);
    end
  endtask

  task automatic test_zero_exempt();
    do_reset();
    tick();
    rd_ex = 5'd0; ra_id = 5'd0; is_load_ex = 1'b1; ra_used_id = 1'b1;
    #1;
    n_checks++;
    if (if_l1.bubble_ex !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_exempt_on: got bub=%b want 0", if_l1.bubble_ex);
    end
    n_checks++;
    if (if_z0.bubble_ex !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_exempt_off: got bub=%b want 1", if_z0.bubble_ex);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (if_z0.stall_cnt !== 32'd1 || if_l1.stall_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL zero_exempt_cnt: got z0=%0d l1=%0d want 1 0",
               if_z0.stall_cnt, if_l1.stall_cnt);
    end
  endtask

  task automatic test_mem_busy();
    logic [6:0] busy, exp_bub, exp_frz, exp_pc;
    int         n_bub, n_pc;
    busy    = 7'b0000110;
    exp_bub = 7'b0011001;
    exp_frz = 7'b0000110;
    exp_pc  = 7'b0011111;
    n_bub = 0; n_pc = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      clear_inputs();
      mem_busy = busy[i];
      if (i == 0) begin
        rd_ex = 5'd9; is_load_ex = 1'b1; ra_id = 5'd9; ra_used_id = 1'b1;
      end
      #1;
      n_bub += int'(if_l3.bubble_ex);
      n_pc  += int'(if_l3.stall_pc);
      n_checks++;
      if (if_l3.bubble_ex !== exp_bub[i] || if_l3.freeze_all !== exp_frz[i] ||
          if_l3.stall_pc !== exp_pc[i] || if_l3.stall_id !== exp_pc[i]) begin
        n_errors++;
        $display("FAIL busy_cycle[%0d]: got bub=%b frz=%b pc=%b id=%b want %b %b %b %b",
                 i, if_l3.bubble_ex, if_l3.freeze_all, if_l3.stall_pc, if_l3.stall_id,
                 exp_bub[i], exp_frz[i], exp_pc[i], exp_pc[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (if_l3.stall_cnt !== 32'd1) begin
          n_errors++;
          $display("FAIL busy_cnt_held: got %0d want 1", if_l3.stall_cnt);
        end
      end
    end
    n_checks++;
    if (n_bub != 3 || n_pc != 5 || if_l3.stall_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL busy_totals: got bubbles=%0d span=%0d cnt=%0d want 3 5 3",
               n_bub, n_pc, if_l3.stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    tick();
    rd_ex = 5'd4; is_load_ex = 1'b1; ra_id = 5'd4; ra_used_id = 1'b1;
    #1;
    n_checks++;
    if (if_l3.bubble_ex !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_stall_start: got bub=%b want 1", if_l3.bubble_ex);
    end
    tick();
    clear_inputs();
    flush_ex = 1'b1;
    #1;
    n_checks++;
    if (if_l3.bubble_ex !== 1'b1 || if_l3.stall_pc !== 1'b0 ||
        if_l3.stall_id !== 1'b0 || if_l3.freeze_all !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_mid_stall: got bub=%b pc=%b id=%b frz=%b want 1 0 0 0",
               if_l3.bubble_ex, if_l3.stall_pc, if_l3.stall_id, if_l3.freeze_all);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (if_l3.bubble_ex !== 1'b0 || if_l3.stall_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL flush_idle_after: got bub=%b cnt=%0d want 0 1",
               if_l3.bubble_ex, if_l3.stall_cnt);
    end
    tick();
    rd_ex = 5'd6; is_load_ex = 1'b1; rb_id = 5'd6; rb_used_id = 1'b1; flush_ex = 1'b1;
    #1;
    n_checks++;
    if (if_l3.bubble_ex !== 1'b1 || if_l3.stall_pc !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_with_hazard: got bub=%b pc=%b want 1 0",
               if_l3.bubble_ex, if_l3.stall_pc);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (if_l3.bubble_ex !== 1'b0 || if_l3.stall_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL flush_hazard_after: got bub=%b cnt=%0d want 0 1",
               if_l3.bubble_ex, if_l3.stall_cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    int n_bub;
    n_bub = 0;
    do_reset();
    // Hazard held continuously: back-to-back sequences with no dead cycle.
    for (int i = 0; i < 20; i++) begin
      tick();
      rd_ex = 5'd3; is_load_ex = 1'b1; ra_id = 5'd3; ra_used_id = 1'b1;
      #1;
      n_bub += int'(if_c4.bubble_ex);
    end
    n_checks++;
    if (n_bub != 20) begin
      n_errors++;
      $display("FAIL back_to_back: got %0d bubbles want 20", n_bub);
    end
    n_checks++;
    if (if_c4.stall_cnt !== 4'd15) begin
      n_errors++;
      $display("FAIL cnt_saturate: got %0d want 15", if_c4.stall_cnt);
    end
    tick();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (if_c4.bubble_ex !== 1'b0 || if_c4.stall_pc !== 1'b0 ||
        if_c4.stall_id !== 1'b0 || if_c4.freeze_all !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_stall: got bub=%b pc=%b id=%b frz=%b want all 0",
               if_c4.bubble_ex, if_c4.stall_pc, if_c4.stall_id, if_c4.freeze_all);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (if_c4.bubble_ex !== 1'b0 || if_c4.stall_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_release: got bub=%b cnt=%0d want 0 0",
               if_c4.bubble_ex, if_c4.stall_cnt);
    end
    tick();
    #1;
    n_checks++;
    if (if_c4.bubble_ex !== 1'b0 || if_c4.stall_pc !== 1'b0) begin
      n_errors++;
      $display("FAIL no_residual: got bub=%b pc=%b want 0 0",
               if_c4.bubble_ex, if_c4.stall_pc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_bubble();
    test_multi_bubble();
    test_zero_exempt();
    test_mem_busy();
    test_flush();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
